// File: rtl/pulse_sign_pkg.sv
// rtl/pulse_sign_pkg.sv - shared types and constants for the step-pulse generator
package pulse_sign_pkg;

    localparam int NMOT_DEF   = 6;
    localparam int PNUM_W_DEF = 10;

    localparam logic DIR_FWD = 1'b0;
    localparam logic DIR_REV = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_HIGH,
        ST_LOW,
        ST_DONE
    } state_t;

endpackage

// File: rtl/pulse_timer.sv
// rtl/pulse_timer.sv - loadable down-counter with a one-cycle expiry flag
module pulse_timer #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    output logic         expire_o
);

    logic [W-1:0] cnt_q;

    // Load wins over counting; the count parks at zero once it runs out.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= load_val_i;
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    // Flags the last cycle of a loaded interval, so a load of N spans N cycles.
    assign expire_o = (cnt_q == W'(1));

endmodule

// File: rtl/pulse_sign.sv
// rtl/pulse_sign.sv - fixed-rate STEP/DIR generator for one of NMOT motors
module pulse_sign
    import pulse_sign_pkg::*;
#(
    parameter int NMOT      = NMOT_DEF,
    parameter int PNUM_W    = PNUM_W_DEF,
    parameter int HALF_CYC  = 500,
    parameter int DIR_SETUP = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [PNUM_W-1:0] PulseNum,
    input  logic              Enable,
    input  logic [2:0]        Motor,
    input  logic [NMOT-1:0]   DRs,
    output logic [NMOT-1:0]   PUs,
    output logic [NMOT-1:0]   DIRs,
    output logic              Busy,
    output logic              Done
);

    localparam int TMAX = (HALF_CYC > DIR_SETUP) ? HALF_CYC : DIR_SETUP;
    localparam int TW   = $clog2(TMAX + 1);

    localparam logic [TW-1:0]   SETUP_LD = TW'(DIR_SETUP);
    localparam logic [TW-1:0]   HALF_LD  = TW'(HALF_CYC);
    localparam logic [3:0]      NMOT_L   = 4'(NMOT);
    localparam logic [NMOT-1:0] ONE_HOT0 = NMOT'(1);

    state_t            state_q;
    logic              en_q;
    logic [PNUM_W-1:0] cnt_q;
    logic [2:0]        m_q;
    logic [NMOT-1:0]   pus_q;
    logic [NMOT-1:0]   dirs_q;
    logic              busy_q;
    logic              done_q;

    logic              start_ok;
    logic              last_pulse;
    logic              tmr_load;
    logic [TW-1:0]     tmr_val;
    logic              tmr_exp;

    // A rising Enable in IDLE with a usable count and a real motor starts a move.
    assign start_ok = (state_q == ST_IDLE) && Enable && !en_q &&
                      (PulseNum != '0) && ({1'b0, Motor} < NMOT_L);

    // The zero test happens on the value before the end-of-LOW decrement.
    assign last_pulse = (cnt_q == PNUM_W'(1));

    // Reload the phase timer whenever a phase begins.
    always_comb begin
        tmr_load = 1'b0;
        tmr_val  = HALF_LD;
        case (state_q)
            ST_IDLE: begin
                if (start_ok) begin
                    tmr_load = 1'b1;
                    tmr_val  = SETUP_LD;
                end
            end
            ST_SETUP, ST_HIGH: tmr_load = tmr_exp;
            ST_LOW:            tmr_load = tmr_exp && !last_pulse;
            default:           tmr_load = 1'b0;
        endcase
    end

    pulse_timer #(
        .W (TW)
    ) u_timer (
        .clk        (clk),
        .rst        (rst),
        .load_i     (tmr_load),
        .load_val_i (tmr_val),
        .expire_o   (tmr_exp)
    );

    // Move sequencer with registered STEP, DIR, Busy and Done outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            en_q    <= 1'b0;
            cnt_q   <= '0;
            m_q     <= '0;
            pus_q   <= '0;
            dirs_q  <= {NMOT{DIR_FWD}};
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            en_q <= Enable;
            case (state_q)
                ST_IDLE: begin
                    if (start_ok) begin
                        cnt_q         <= PulseNum;
                        m_q           <= Motor;
                        dirs_q[Motor] <= DRs[Motor];
                        busy_q        <= 1'b1;
                        state_q       <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    if (tmr_exp) begin
                        pus_q   <= ONE_HOT0 << m_q;
                        state_q <= ST_HIGH;
                    end
                end
                ST_HIGH: begin
                    if (tmr_exp) begin
                        pus_q   <= '0;
                        state_q <= ST_LOW;
                    end
                end
                ST_LOW: begin
                    if (tmr_exp) begin
                        cnt_q <= cnt_q - 1'b1;
                        if (last_pulse) begin
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            state_q <= ST_DONE;
                        end else begin
                            pus_q   <= ONE_HOT0 << m_q;
                            state_q <= ST_HIGH;
                        end
                    end
                end
                ST_DONE: begin
                    done_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign PUs  = pus_q;
    assign DIRs = dirs_q;
    assign Busy = busy_q;
    assign Done = done_q;

endmodule

// File: tb/tb_pulse_sign.sv
// tb/tb_pulse_sign.sv - randomized self-checking bench for pulse_sign
module tb_pulse_sign;
    import pulse_sign_pkg::*;

    localparam int HALF = 2;
    localparam int DS   = 3;
    localparam int NM   = 6;
    localparam int PW   = 10;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [PW-1:0] PulseNum = '0;
    logic          Enable = 1'b0;
    logic [2:0]    Motor = '0;
    logic [NM-1:0] DRs = '0;
    logic [NM-1:0] PUs;
    logic [NM-1:0] DIRs;
    logic          Busy;
    logic          Done;

    pulse_sign #(
        .NMOT      (NM),
        .PNUM_W    (PW),
        .HALF_CYC  (HALF),
        .DIR_SETUP (DS)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .PulseNum (PulseNum),
        .Enable   (Enable),
        .Motor    (Motor),
        .DRs      (DRs),
        .PUs      (PUs),
        .DIRs     (DIRs),
        .Busy     (Busy),
        .Done     (Done)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;

    task automatic check(input string tag, input longint obs, input longint exp);
        n_checks++;
        if (obs != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Observed move statistics, gathered every cycle.
    int            cyc = 0;
    int            clr_gen = 0;
    int            seen_gen = 0;
    int            busy_cyc, done_cnt, done_bad, onehot_err, width_err, first_dly;
    int            rises [NM];
    int            busy_start, hi_len, lo_len;
    bit            seen_rise;
    logic          prev_busy = 1'b0;
    logic [NM-1:0] prev_pus = '0;

    always @(negedge clk) begin
        cyc++;
        if (clr_gen != seen_gen) begin
            seen_gen   = clr_gen;
            busy_cyc   = 0;
            done_cnt   = 0;
            done_bad   = 0;
            onehot_err = 0;
            width_err  = 0;
            first_dly  = -1;
            seen_rise  = 1'b0;
            hi_len     = 0;
            lo_len     = 0;
            for (int i = 0; i < NM; i++) rises[i] = 0;
        end
        if (Busy) busy_cyc++;
        if (Busy && !prev_busy) begin
            busy_start = cyc;
            seen_rise  = 1'b0;
        end
        if (Done) begin
            done_cnt++;
            if (!prev_busy || Busy) done_bad++;
        end
        if ($countones(PUs) > 1) onehot_err++;
        for (int i = 0; i < NM; i++)
            if (PUs[i] && !prev_pus[i]) rises[i]++;
        if ((|PUs) && !(|prev_pus)) begin
            if (!seen_rise) begin
                first_dly = cyc - busy_start;
                seen_rise = 1'b1;
            end else if (lo_len != HALF) begin
                width_err++;
            end
            hi_len = 1;
        end else if (|PUs) begin
            hi_len++;
        end
        if (!(|PUs) && (|prev_pus)) begin
            if (hi_len != HALF) width_err++;
            lo_len = 1;
        end else if (!(|PUs)) begin
            lo_len++;
        end
        if (!Busy && prev_busy && seen_rise && lo_len != HALF + 1) width_err++;
        prev_busy = Busy;
        prev_pus  = PUs;
    end

    // Reference direction state: what each driver line should hold.
    logic [NM-1:0] dir_m = '0;

    task automatic clear_stats();
        clr_gen++;
        @(negedge clk);
    endtask

    task automatic pulse_enable(input int n, input int mot, input logic [NM-1:0] dr);
        PulseNum = PW'(n);
        Motor    = 3'(mot);
        DRs      = dr;
        Enable   = 1'b1;
        @(negedge clk);
        Enable   = 1'b0;
    endtask

    task automatic wait_done(input int bound, output bit got);
        got = 1'b0;
        for (int i = 0; i < bound; i++) begin
            @(negedge clk);
            if (Done) begin
                got = 1'b1;
                break;
            end
        end
        repeat (3) @(negedge clk);
        @(posedge clk);
        #1;
    endtask

    // Compare a finished move against the rules: acceptance, pulse count, timing, DIR.
    task automatic check_move(input int n, input int mot, input logic [NM-1:0] dr, input bit got);
        bit accepted;
        int others;
        accepted = (n != 0) && (mot < NM);
        if (accepted) dir_m[mot] = dr[mot];
        others = 0;
        for (int i = 0; i < NM; i++)
            if (!accepted || i != mot) others += rises[i];
        check("busy_len", busy_cyc, accepted ? DS + 2 * HALF * n : 0);
        check("done_cnt", done_cnt, accepted ? 1 : 0);
        check("other_rises", others, 0);
        check("dirs", DIRs, dir_m);
        check("onehot", onehot_err, 0);
        check("done_after_busy", done_bad, 0);
        if (accepted) begin
            check("done_seen", got, 1);
            check("rises", rises[mot], n);
            check("first_rise_dly", first_dly, DS);
            check("pulse_width", width_err, 0);
        end
    endtask

    task automatic run_move(input int n, input int mot, input logic [NM-1:0] dr);
        bit got;
        clear_stats();
        pulse_enable(n, mot, dr);
        wait_done(DS + 2 * HALF * n + 10, got);
        check_move(n, mot, dr, got);
    endtask

    initial begin
        bit got;
        int n, mot;
        logic [NM-1:0] dr;

        // Reset state.
        repeat (2) @(negedge clk);
        check("rst_pus", PUs, 0);
        check("rst_busy", Busy, 0);
        check("rst_dirs", DIRs, 0);
        check("rst_done", Done, 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Reset mid-HIGH: outputs drop asynchronously.
        pulse_enable(3, 1, {NM{DIR_REV}});
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (|PUs) got = 1'b1;
        end
        check("reach_high", got, 1);
        check("dir_before_rst", DIRs, 6'b000010);
        #2 rst = 1'b1;
        #1;
        check("async_pus", PUs, 0);
        check("async_busy", Busy, 0);
        check("async_dirs", DIRs, 0);
        @(negedge clk);
        rst   = 1'b0;
        dir_m = '0;
        repeat (6) @(negedge clk);
        check("post_rst_busy", Busy, 0);
        check("post_rst_pus", PUs, 0);

        // Basic move.
        run_move(3, 2, 6'b000100);

        // Rejected starts leave everything untouched.
        run_move(0, 1, 6'b111111);
        run_move(5, 6, 6'b111111);

        // Enable held high plus an extra mid-move pulse: one move only.
        clear_stats();
        PulseNum = 10'd2;
        Motor    = 3'd3;
        DRs      = 6'b001000;
        Enable   = 1'b1;
        repeat (6) @(negedge clk);
        Enable = 1'b0;
        @(negedge clk);
        Enable = 1'b1;
        repeat (25) @(negedge clk);
        @(posedge clk);
        #1;
        dir_m[3] = 1'b1;
        check("hold_done_cnt", done_cnt, 1);
        check("hold_rises", rises[3], 2);
        check("hold_busy_len", busy_cyc, DS + 4 * HALF);
        @(negedge clk);
        Enable = 1'b0;
        @(negedge clk);
        run_move(2, 3, 6'b000000);

        // Inputs changed mid-move have no effect.
        clear_stats();
        pulse_enable(4, 4, 6'b010000);
        repeat (5) @(negedge clk);
        PulseNum = 10'd9;
        DRs      = 6'b101111;
        wait_done(DS + 2 * HALF * 4 + 10, got);
        check_move(4, 4, 6'b010000, got);

        // Maximum count.
        run_move(1023, 0, 6'b000000);

        // Randomized moves, including rejected ones.
        for (int k = 0; k < 12; k++) begin
            n   = $urandom_range(0, 6);
            mot = $urandom_range(0, 7);
            dr  = NM'($urandom);
            run_move(n, mot, dr);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/pulse_sign.md
Name: pulse_sign

Overview:
Step-pulse generator directly downstream of the Control block. It consumes the pulse count, start strobe and direction vector that Control produces, and emits a fixed-rate STEP (PU) train and a latched direction (DIR) line for the one selected motor. It reports Busy back to Control, which uses Busy to gate its next command. The block drives six stepper drivers; only one motor moves at a time.

Parameters:
NMOT, 6, number of motor channels
PNUM_W, 10, width of the pulse count
HALF_CYC, 500, clk cycles per half step period (PU high time = PU low time); minimum 1
DIR_SETUP, 10, clk cycles between the DIR update and the first PU rising edge; minimum 1

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
PulseNum  in  PNUM_W  number of step pulses to emit
Enable  in  1  start request; acted on at its rising edge
Motor  in  3  target motor index, 0..NMOT-1
DRs  in  NMOT  direction request per motor (1 = reverse, 0 = forward)
PUs  out  NMOT  step pulse per motor
DIRs  out  NMOT  latched direction per motor, to the drivers
Busy  out  1  high while a move is in progress
Done  out  1  one-cycle pulse when a move completes

Behaviour:
- Reset (async, rst=1): all outputs are 0 (PUs=0, DIRs=0, Busy=0, Done=0). The state is IDLE, all counters are 0, and the Enable edge register is 0. A reset mid-move drops PU low immediately and abandons the move.
- Start detection: en_q registers Enable. A start event is Enable & ~en_q, sampled in IDLE.
- A start is accepted only if PulseNum != 0 and Motor < NMOT. Otherwise it is ignored silently: no Busy, no Done.
- Start events seen while not in IDLE are ignored and are not queued.
- On an accepted start at edge n:
  - Latch cnt <= PulseNum and m <= Motor.
  - Set DIRs[m] <= DRs[m]. The other DIRs bits are unchanged.
  - Busy=1 from edge n. Enter SETUP.
- State machine:
  - IDLE: wait for an accepted start.
  - SETUP: hold for DIR_SETUP cycles, then go to HIGH.
  - HIGH: PUs[m]=1 for HALF_CYC cycles, then go to LOW.
  - LOW: PUs[m]=0 for HALF_CYC cycles. At the end of LOW, cnt is decremented.
    - If the decremented value is 0, go to DONE.
    - Otherwise go to HIGH.
  - DONE: lasts one cycle. Done=1 and Busy=0 in that cycle. Then go to IDLE.
- Timing:
  - Busy stays high for exactly DIR_SETUP + 2*HALF_CYC*PulseNum cycles.
  - Done asserts on the cycle immediately after Busy falls.
- PUs bits other than m are always 0. PUs is registered and glitch-free.
- Inputs PulseNum, Motor and DRs are sampled only at the accepted start. Changes during a move have no effect.
- The DIR value persists after the move until the next accepted start for that motor.
- Enable held high does not retrigger. Enable must return low and rise again to start a new move.
- If Enable rises in the same cycle the block returns to IDLE (the DONE cycle), the start is ignored, because the block is not in IDLE when it is sampled.
- Counter widths:
  - Phase timer width: $clog2(max(HALF_CYC, DIR_SETUP)+1).
  - cnt is PNUM_W bits with no wrap. The 0 check is made before the decrement.
  - A maximum count of 1023 must produce exactly 1023 pulses.

Decomposition:
- A shared package holds:
  - the state enum (IDLE, SETUP, HIGH, LOW, DONE);
  - the NMOT and PNUM_W defaults;
  - the direction encoding constants DIR_FWD=0 and DIR_REV=1.
- One sub-module, pulse_timer: a loadable down-counter with a load value input and a one-cycle expiry flag. It is reused for the SETUP, HIGH and LOW phase durations.

Test Plan (HALF_CYC=2, DIR_SETUP=3):
- Reset all outputs: assert rst mid-HIGH phase -> PUs=0, Busy=0 and DIRs=0 in the same cycle (async); after release the block is in IDLE.
- Basic move: PulseNum=3, Motor=2, DRs=6'b000100, Enable rising -> DIRs[2]=1; exactly 3 pulses on PUs[2], each 2 cycles high and 2 low; first rise 3 cycles after Busy rises; Busy high for 15 cycles; one Done pulse; other PUs bits stay 0.
- Rejected starts: PulseNum=0 -> no Busy and no Done. Motor=6 with PulseNum=5 -> no Busy and no Done. In both cases DIRs is unchanged.
- Retrigger/hold: Enable held high through a whole move, plus a second Enable pulse mid-move -> exactly one move. After Enable falls and rises again, a second move runs.
- Input stability: PulseNum and DRs changed mid-move (4 -> 9, DRs bit flipped) -> still 4 pulses and DIRs unchanged until the next start.
- Max count: PulseNum=1023, Motor=0 -> exactly 1023 PUs[0] rising edges; Busy length 3+4*1023 = 4095 cycles.
